// File: rtl/switch_conditioner_pkg.sv
// Shared types and constants for the switch conditioner slice.
package switch_conditioner_pkg;

    // Per-bit debounce state, 1-bit encoding
    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } sw_state_e;

    localparam int unsigned SW_WIDTH            = 4;
    localparam int unsigned SW_DEBOUNCE_DEFAULT = 500000;

    // Bits needed to hold 0..cycles inclusive
    function automatic int unsigned sw_cnt_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/switch_conditioner_debounce_bit.sv
// One switch bit: synchroniser, STABLE/COUNTING FSM and stability counter.
// Module name kept as switch_debounce_bit for drop-in compatibility.
module switch_debounce_bit
    import switch_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic changed,
    output logic stable
);

    localparam int unsigned    CW   = sw_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  TERM = CW'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    sw_state_e              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   pulse_q, pulse_d;

    // Synchroniser chain; only the last stage is used downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= STABLE;
        else        state_q <= state_d;
    end

    // Next-state: leave STABLE on a mismatch, return on bounce-back or acceptance
    always_comb begin
        state_d = state_q;
        case (state_q)
            STABLE:   if (sync != level_q) state_d = COUNTING;
            COUNTING: if (sync == level_q || cnt_q == TERM) state_d = STABLE;
            default:  state_d = STABLE;
        endcase
    end

    // Datapath next values: counter, accepted level and change pulse
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        pulse_d = 1'b0;
        case (state_q)
            STABLE: begin
                if (sync != level_q) cnt_d = CW'(1);
            end
            COUNTING: begin
                if (sync != level_q) begin
                    if (cnt_q == TERM) begin
                        level_d = ~level_q;
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: cnt_d = '0;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    // Outputs
    always_comb begin
        level   = level_q;
        changed = pulse_q;
        stable  = (state_q == STABLE);
    end

endmodule

// File: rtl/switch_conditioner.sv
// Switch conditioner: per-bit sync + debounce feeding the switches PIO.
// Optional sticky change interrupts when SWITCH_CONDITIONER_IRQ_EN is defined.
module switch_conditioner
    import switch_conditioner_pkg::*;
#(
    parameter int unsigned WIDTH           = SW_WIDTH,
    parameter int unsigned DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] switches_export,
    output logic [WIDTH-1:0] sw_changed,
    output logic             sw_settled
`ifdef SWITCH_CONDITIONER_IRQ_EN
    ,
    input  logic [WIDTH-1:0] irq_clear,
    output logic [WIDTH-1:0] irq_pending
`endif
);

    logic [WIDTH-1:0] stable_vec;
    logic             settled_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        switch_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_bit (
            .clk     (clk_clk),
            .rst_n   (reset_reset_n),
            .raw     (sw_raw[i]),
            .level   (switches_export[i]),
            .changed (sw_changed[i]),
            .stable  (stable_vec[i])
        );
    end

    // Settled flag reflects the previous cycle's per-bit states
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) settled_q <= 1'b1;
        else                settled_q <= &stable_vec;
    end

    assign sw_settled = settled_q;

`ifdef SWITCH_CONDITIONER_IRQ_EN
    logic [WIDTH-1:0] pending_q;

    // Sticky pending bits; a new change overrides a same-cycle clear
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) pending_q <= '0;
        else                pending_q <= (pending_q & ~irq_clear) | sw_changed;
    end

    assign irq_pending = pending_q;
`endif

endmodule

// File: doc/switch_conditioner.md
Name: switch_conditioner

Overview:
- Sits directly upstream of the system's switches PIO input (switches_export) and drives it from the raw board slide switches.
- Synchronises each asynchronous switch bit to clk_clk and debounces it per bit with a counter-based state machine.
- Presents a glitch-free switch vector and emits a one-cycle change pulse per bit.

Parameters:
- WIDTH, 4, number of switch bits; matches the switches_export width.
- DEBOUNCE_CYCLES, 500000, number of consecutive stable clk_clk cycles required before a new level is accepted (10 ms at 50 MHz); legal range 1 to 2^24.
- SYNC_STAGES, 2, number of synchroniser flops per bit; legal range 2 to 4.

Ports:
- clk_clk  input  1  system clock, shared with the SoC.
- reset_reset_n  input  1  asynchronous, active-low reset.
- sw_raw  input  WIDTH  raw board switch levels, asynchronous and bouncy.
- switches_export  output  WIDTH  debounced switch levels, fed to the PIO.
- sw_changed  output  WIDTH  one-cycle pulse on each bit whose debounced level just flipped.
- sw_settled  output  1  high while every bit is in the STABLE state.

Behaviour:
- Reset is asynchronous assert, synchronous deassert handled by the system.
- During reset: synchroniser flops = 0, switches_export = 0, sw_changed = 0, all counters = 0, all bits in STABLE.
- sw_settled = 1 while in reset and during the first cycle after reset.
- Each bit passes through SYNC_STAGES flops to give sync[i]. Only sync[i] is used downstream.
- Per-bit FSM has two states, STABLE and COUNTING.
  - STABLE, sync[i] == switches_export[i]: stay in STABLE; counter held at 0.
  - STABLE, sync[i] != switches_export[i]: go to COUNTING; counter loads 1.
  - COUNTING, sync[i] == switches_export[i] (bounce back): return to STABLE; counter cleared; no output change; no pulse.
  - COUNTING, sync[i] != switches_export[i] and counter < DEBOUNCE_CYCLES: counter increments.
  - COUNTING, sync[i] != switches_export[i] and counter == DEBOUNCE_CYCLES: on the next edge switches_export[i] toggles, sw_changed[i] = 1 for exactly that one cycle, the bit returns to STABLE and the counter clears.
- Latency from a clean edge on sw_raw[i] to switches_export[i] is SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles, fixed and deterministic.
- DEBOUNCE_CYCLES = 1: the bit is accepted after one cycle in COUNTING; latency is SYNC_STAGES + 2.
- Counter width is ceil(log2(DEBOUNCE_CYCLES+1)). The counter never wraps; comparison uses equality at the terminal value.
- Bits are fully independent. Any number of bits may change in the same cycle, each producing its own pulse.
- sw_settled is registered: 1 when all bits were in STABLE on the previous cycle.
- Reset asserted mid-count aborts all counts immediately. Outputs return to their reset values with no pulse emitted.
- After reset release, a switch held at 1 is reported as a change 0->1 after the full debounce latency, with a sw_changed pulse.

Optional Feature:
- Macro: SWITCH_CONDITIONER_IRQ_EN.
- When defined, the block adds two ports:
  - irq_clear, input, WIDTH: write-one-to-clear.
  - irq_pending, output, WIDTH: sticky, set by sw_changed[i], cleared by irq_clear[i]; reset to 0.
  - If set and clear occur in the same cycle, set wins.
  - irq_pending is registered, one cycle after sw_changed.
- When not defined, neither port exists and no sticky flops are synthesised.

Decomposition:
- Package switch_conditioner_pkg holds:
  - the state enum (STABLE, COUNTING), encoded in 1 bit;
  - default constants SW_WIDTH = 4 and SW_DEBOUNCE_DEFAULT = 500000;
  - a counter-width function based on clog2.
- Sub-module switch_debounce_bit implements the synchroniser, FSM and counter for one bit.
- The top level instantiates switch_debounce_bit WIDTH times in a generate loop and implements sw_settled and the optional IRQ logic.

Test Plan:
Bench uses DEBOUNCE_CYCLES = 8 and SYNC_STAGES = 2.
- Reset with sw_raw = 4'b0000, then release -> switches_export = 0, sw_changed = 0 and sw_settled = 1 in every cycle.
- sw_raw[0] steps cleanly 0->1 -> switches_export[0] rises exactly 11 cycles later; sw_changed = 4'b0001 for exactly 1 cycle; sw_settled is low during the count.
- sw_raw[1] toggles every 3 cycles for 40 cycles, then holds 1 -> no output change during bouncing; a single rise 11 cycles after the final edge; a single pulse.
- sw_raw steps 4'b0000->4'b1111 in one cycle -> all four bits rise on the same cycle; sw_changed = 4'b1111 for 1 cycle.
- Reset asserted 5 cycles into a count on bit 2 -> outputs 0 immediately. After release with sw_raw[2] still 1, the bit rises 11 cycles after release.
- With SWITCH_CONDITIONER_IRQ_EN defined: bit 3 change sets irq_pending[3]; irq_clear[3] asserted in the same cycle as a new sw_changed[3] -> irq_pending[3] stays 1; a clear alone -> 0 next cycle.
